// File: rtl/minv_mdiv_host.sv
// Host sequencer for the modular inverse/division core: loads p/a/b as 16-bit words,
// starts the core, waits for rdy and unloads the selected result register. Optional WAIT timeout: MINV_HOST_TIMEOUT_EN.
module minv_mdiv_host #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_mdiv,
    input  logic         cmd_reload_p,
    input  logic [255:0] op_a,
    input  logic [255:0] op_b,
    input  logic [255:0] op_p,
    output logic [255:0] res,
    output logic         res_valid,
    output logic         res_err,
    output logic         busy,
    output logic [15:0]  datain,
    output logic         loada,
    output logic         loadb,
    output logic         loadp,
    output logic         outx1,
    output logic         outx2,
    output logic         minv_mdiv,
    output logic         minv_mdiv_en,
    input  logic         minv_mdiv_rdy,
    input  logic         minv_mdiv_flag,
    input  logic [15:0]  regx1out,
    input  logic [15:0]  regx2out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADP,
        S_LOADA,
        S_LOADB,
        S_START,
        S_WAIT,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    word_cnt_q;
    logic [7:0]    word_base;
    logic [255:0]  a_q, b_q, p_q, res_q;
    logic          mdiv_q, p_loaded_q, sel_q, wait_armed_q;
    logic          accept, last_word, core_done, timeout_hit;

    assign word_base = {word_cnt_q, 4'b0000};
    assign last_word = (word_cnt_q == 4'hF);
    assign accept    = cmd_valid & cmd_ready;
    // wait_armed_q is set only after one full WAIT cycle, masking rdy in the first one
    assign core_done = (state_q == S_WAIT) & wait_armed_q & minv_mdiv_rdy;
    assign res       = res_q;

`ifdef MINV_HOST_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt_q;
    logic        res_err_q;

    assign timeout_hit = (state_q == S_WAIT) && !core_done && (wait_cnt_q == WAIT_LAST);
    assign res_err     = res_err_q;
`else
    assign timeout_hit = 1'b0;
    assign res_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        datain       = '0;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadp        = 1'b0;
        outx1        = 1'b0;
        outx2        = 1'b0;
        minv_mdiv_en = 1'b0;
        res_valid    = 1'b0;
        busy         = (state_q != S_IDLE);
        minv_mdiv    = (state_q != S_IDLE) & ~mdiv_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    state_d = (cmd_reload_p || !p_loaded_q) ? S_LOADP : S_LOADA;
                end
            end
            S_LOADP: begin
                loadp  = 1'b1;
                datain = p_q[word_base +: 16];
                if (last_word) state_d = S_LOADA;
            end
            S_LOADA: begin
                loada  = 1'b1;
                datain = a_q[word_base +: 16];
                if (last_word) state_d = mdiv_q ? S_LOADB : S_START;
            end
            S_LOADB: begin
                loadb  = 1'b1;
                datain = b_q[word_base +: 16];
                if (last_word) state_d = S_START;
            end
            S_START: begin
                minv_mdiv_en = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_UNLOAD;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_UNLOAD: begin
                outx1 = ~sel_q;
                outx2 = sel_q;
                if (last_word) state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt_q   <= '0;
            a_q          <= '0;
            b_q          <= '0;
            p_q          <= '0;
            res_q        <= '0;
            mdiv_q       <= 1'b0;
            p_loaded_q   <= 1'b0;
            sel_q        <= 1'b0;
            wait_armed_q <= 1'b0;
`ifdef MINV_HOST_TIMEOUT_EN
            wait_cnt_q   <= '0;
            res_err_q    <= 1'b0;
`endif
        end else begin
            // 4-bit counter wraps to zero exactly as each 16-word phase ends
            if (state_q inside {S_LOADP, S_LOADA, S_LOADB, S_UNLOAD}) begin
                word_cnt_q <= word_cnt_q + 4'd1;
            end else begin
                word_cnt_q <= '0;
            end
            wait_armed_q <= (state_q == S_WAIT);
            if (accept) begin
                a_q    <= op_a;
                b_q    <= op_b;
                p_q    <= op_p;
                mdiv_q <= cmd_mdiv;
                res_q  <= '0;
            end
            if (state_q == S_LOADP && last_word) begin
                p_loaded_q <= 1'b1;
            end
            if (core_done) begin
                sel_q <= minv_mdiv_flag;
            end
            if (state_q == S_UNLOAD) begin
                res_q[word_base +: 16] <= sel_q ? regx2out : regx1out;
            end
`ifdef MINV_HOST_TIMEOUT_EN
            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 16'd1 : '0;
            if (accept) begin
                res_err_q <= 1'b0;
            end
            if (timeout_hit) begin
                res_err_q  <= 1'b1;
                res_q      <= '0;
                p_loaded_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_minv_mdiv_host.sv
// Self-checking bench for minv_mdiv_host: behavioural core model plus directed and randomized commands.
module tb_minv_mdiv_host;

`ifdef MINV_HOST_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 20;
`else
    localparam int unsigned TB_TIMEOUT = 65535;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_mdiv, cmd_reload_p;
    logic [255:0] op_a, op_b, op_p, res;
    logic         res_valid, res_err, busy;
    logic [15:0]  datain;
    logic         loada, loadb, loadp, outx1, outx2;
    logic         minv_mdiv, minv_mdiv_en, minv_mdiv_rdy, minv_mdiv_flag;
    logic [15:0]  regx1out, regx2out;

    minv_mdiv_host #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mdiv(cmd_mdiv), .cmd_reload_p(cmd_reload_p),
        .op_a(op_a), .op_b(op_b), .op_p(op_p),
        .res(res), .res_valid(res_valid), .res_err(res_err), .busy(busy),
        .datain(datain), .loada(loada), .loadb(loadb), .loadp(loadp),
        .outx1(outx1), .outx2(outx2),
        .minv_mdiv(minv_mdiv), .minv_mdiv_en(minv_mdiv_en),
        .minv_mdiv_rdy(minv_mdiv_rdy), .minv_mdiv_flag(minv_mdiv_flag),
        .regx1out(regx1out), .regx2out(regx2out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- behavioural core model ----------------
    logic [255:0] core_res, core_junk;
    bit           core_flag, core_never;
    int           core_lat;
    logic [255:0] reg_x1 = '0, reg_x2 = '0;
    bit           core_busy = 1'b0;
    int           core_ctr = 0;

    always @(posedge clk) begin
        if (!rst) begin
            core_busy <= 1'b0;
            core_ctr  <= 0;
        end else if (minv_mdiv_en) begin
            core_busy <= 1'b1;
            core_ctr  <= 0;
            reg_x1    <= core_flag ? core_junk : core_res;
            reg_x2    <= core_flag ? core_res : core_junk;
        end else begin
            if (core_busy) core_ctr <= core_ctr + 1;
            if (outx1) reg_x1 <= reg_x1 >> 16;
            if (outx2) reg_x2 <= reg_x2 >> 16;
        end
    end

    assign minv_mdiv_rdy  = core_busy && !core_never && (core_ctr >= core_lat);
    assign minv_mdiv_flag = core_flag;
    assign regx1out       = reg_x1[15:0];
    assign regx2out       = reg_x2[15:0];

    // ---------------- output monitor (samples on negedge) ----------------
    int          ncyc = 0;
    logic [15:0] pw[$], aw[$], bw[$];
    int          n_x1, n_x2, n_en, n_rv, first_load, en_n, ox_n, rv_n;
    int          onehot_err, datain_err, mode_err, busy_n;
    bit          cur_mdiv;

    always @(negedge clk) begin
        ncyc++;
        if (loadp) pw.push_back(datain);
        if (loada) aw.push_back(datain);
        if (loadb) bw.push_back(datain);
        if ((loadp || loada || loadb) && first_load < 0) first_load = ncyc;
        if (minv_mdiv_en) begin
            n_en++;
            if (en_n < 0) en_n = ncyc;
        end
        if ((outx1 || outx2) && ox_n < 0) ox_n = ncyc;
        if (outx1) n_x1++;
        if (outx2) n_x2++;
        if (res_valid) begin
            n_rv++;
            if (rv_n < 0) rv_n = ncyc;
        end
        if (busy === 1'b1) busy_n++;
        if ($countones({loada, loadb, loadp, outx1, outx2, minv_mdiv_en}) > 1) onehot_err++;
        if (!(loada || loadb || loadp) && datain !== 16'h0) datain_err++;
        if ((busy === 1'b1) ? (minv_mdiv !== ~cur_mdiv) : (minv_mdiv !== 1'b0)) mode_err++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [255:0] words_to_vec(input logic [15:0] q[$]);
        logic [255:0] v = '0;
        for (int i = 0; i < q.size() && i < 16; i++) v[16*i +: 16] = q[i];
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // modular inverse (a^-1 mod p) or division (b/a mod p) by exhaustive search
    function automatic logic [255:0] ref_res(input bit mdiv, input longint a, input longint b, input longint p);
        longint inv = 0;
        for (longint x = 1; x < p; x++) if ((a * x) % p == 1) inv = x;
        return mdiv ? 256'((b * inv) % p) : 256'(inv);
    endfunction

    bit p_cached = 1'b0;

    task automatic run_cmd(input bit mdiv, input bit reload, input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] p, input logic [255:0] exp_res, input bit flag,
                           input int lat, input bit tmo);
        int acc, guard, nload;
        bit exp_loadp;
        exp_loadp  = reload || !p_cached;
        nload      = int'(exp_loadp) + 1 + int'(mdiv);
        core_res   = exp_res;
        core_flag  = flag;
        core_lat   = lat;
        core_never = tmo;
        core_junk  = rand256();
        cur_mdiv   = mdiv;
        pw.delete(); aw.delete(); bw.delete();
        n_x1 = 0; n_x2 = 0; n_en = 0; n_rv = 0; first_load = -1; en_n = -1; ox_n = -1; rv_n = -1;
        onehot_err = 0; datain_err = 0; mode_err = 0; busy_n = 0;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        check("ready_wait", 256'(guard < 100), 256'(1));
        acc          = ncyc;
        cmd_valid    = 1'b1;
        cmd_mdiv     = mdiv;
        cmd_reload_p = reload;
        op_a = a; op_b = b; op_p = p;
        step();
        // stray requests while busy must be ignored
        op_a = ~a; op_b = ~b; op_p = ~p; cmd_mdiv = ~mdiv; cmd_reload_p = ~reload;
        repeat (3) step();
        cmd_valid = 1'b0;
        guard = 0;
        while (rv_n < 0 && guard < 3000) begin
            step();
            guard++;
        end
        check("done_wait", 256'(rv_n >= 0), 256'(1));
        step();
        check("ready_after_done", 256'(cmd_ready), 256'(1));
        check("busy_after_done", 256'(busy), 256'(0));
        check("rv_pulse", 256'(n_rv), 256'(1));
        check("loadp_cnt", 256'(pw.size()), exp_loadp ? 256'(16) : 256'(0));
        if (exp_loadp) check("p_words", words_to_vec(pw), p);
        check("loada_cnt", 256'(aw.size()), 256'(16));
        check("a_words", words_to_vec(aw), a);
        check("loadb_cnt", 256'(bw.size()), mdiv ? 256'(16) : 256'(0));
        if (mdiv) check("b_words", words_to_vec(bw), b);
        check("first_load", 256'(first_load), 256'(acc + 1));
        check("en_cnt", 256'(n_en), 256'(1));
        check("en_time", 256'(en_n), 256'(acc + 16 * nload + 1));
        if (tmo) begin
            check("outx_none", 256'(n_x1 + n_x2), 256'(0));
            check("rv_time_tmo", 256'(rv_n), 256'(en_n + 1 + int'(TB_TIMEOUT)));
        end else begin
            check("outx1_cnt", 256'(n_x1), flag ? 256'(0) : 256'(16));
            check("outx2_cnt", 256'(n_x2), flag ? 256'(16) : 256'(0));
            check("unload_time", 256'(ox_n), 256'(en_n + 2 + (lat > 1 ? lat : 1)));
            check("rv_time", 256'(rv_n), 256'(ox_n + 16));
        end
        check("res", res, tmo ? 256'(0) : exp_res);
        check("res_err", 256'(res_err), 256'(tmo));
        check("busy_cycles", 256'(busy_n), 256'(rv_n - acc));
        check("onehot", 256'(onehot_err), 256'(0));
        check("datain_idle", 256'(datain_err), 256'(0));
        check("mode_hold", 256'(mode_err), 256'(0));
        if (exp_loadp) p_cached = 1'b1;
        if (tmo) p_cached = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 256'({datain, loada, loadb, loadp, outx1, outx2, minv_mdiv_en, res_valid,
                         res_err, busy, minv_mdiv, cmd_ready}), 256'(0));
        check({tag, "_res"}, res, 256'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    int unsigned primes[6] = '{7, 11, 13, 101, 251, 65521};

    initial begin
        logic [255:0] a, b, p, r, last_p;
        bit mdiv, reload, flag, last_small;
        int lat;
        rst = 1'b0; cmd_valid = 1'b0; cmd_mdiv = 1'b0; cmd_reload_p = 1'b0;
        op_a = '0; op_b = '0; op_p = '0;
        core_res = '0; core_junk = '0; core_flag = 1'b0; core_never = 1'b0; core_lat = 0;
        cur_mdiv = 1'b0;
        repeat (3) step();
        check_all_zero("reset_outputs");
        rst = 1'b1;
        step();
        check("ready_after_reset", 256'(cmd_ready), 256'(1));

        // inverse 3^-1 mod 7 = 5, p reloaded, result in x1
        check("ref_inv", ref_res(1'b0, 3, 0, 7), 256'(5));
        run_cmd(1'b0, 1'b1, 256'(3), 256'(0), 256'(7), 256'(5), 1'b0, 3, 1'b0);
        // p cached: first loada right after accept
        run_cmd(1'b0, 1'b0, 256'(3), 256'(0), 256'(7), 256'(5), 1'b0, 2, 1'b0);
        // division 4/3 mod 7 = 6, result in x2
        check("ref_div", ref_res(1'b1, 3, 4, 7), 256'(6));
        run_cmd(1'b1, 1'b0, 256'(3), 256'(4), 256'(7), 256'(6), 1'b1, 4, 1'b0);
        // rdy already high in the first WAIT cycle
        run_cmd(1'b0, 1'b0, 256'(3), 256'(0), 256'(7), 256'(5), 1'b0, 0, 1'b0);

        last_p = 256'(7);
        last_small = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mdiv   = 1'($urandom_range(0, 1));
            reload = 1'($urandom_range(0, 1));
            flag   = 1'($urandom_range(0, 1));
            lat    = int'($urandom_range(0, 12));
            if (i % 2 == 0) begin
                if (!(p_cached && last_small && !reload)) begin
                    reload = 1'b1;
                    p = 256'(primes[$urandom_range(0, 5)]);
                end else begin
                    p = last_p;
                end
                a = 256'($urandom_range(1, int'(p[31:0]) - 1));
                b = 256'($urandom_range(0, int'(p[31:0]) - 1));
                r = ref_res(mdiv, longint'(a[31:0]), longint'(b[31:0]), longint'(p[31:0]));
                last_small = 1'b1;
                last_p = p;
            end else begin
                a = rand256(); b = rand256(); p = rand256(); r = rand256();
                if (reload || !p_cached) last_small = 1'b0;
            end
            run_cmd(mdiv, reload, a, b, p, r, flag, lat, 1'b0);
        end

        // reset in the middle of LOADA
        run_cmd(1'b0, 1'b1, 256'(3), 256'(0), 256'(7), 256'(5), 1'b0, 1, 1'b0);
        cmd_valid = 1'b1; cmd_mdiv = 1'b0; cmd_reload_p = 1'b0;
        op_a = rand256(); op_p = 256'(7);
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        check("mid_loada", 256'(loada), 256'(1));
        rst = 1'b0;
        step();
        check_all_zero("midrst_outputs");
        rst = 1'b1;
        p_cached = 1'b0;
        step();
        check("ready_after_midrst", 256'(cmd_ready), 256'(1));
        run_cmd(1'b1, 1'b0, 256'(3), 256'(4), 256'(7), 256'(6), 1'b1, 5, 1'b0);

`ifdef MINV_HOST_TIMEOUT_EN
        run_cmd(1'b0, 1'b1, rand256(), rand256(), rand256(), rand256(), 1'b0, 0, 1'b1);
        run_cmd(1'b0, 1'b0, 256'(3), 256'(0), 256'(7), 256'(5), 1'b0, 2, 1'b0);
`else
        run_cmd(1'b0, 1'b0, rand256(), rand256(), rand256(), rand256(), 1'b1, 40, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
